// File: rtl/bp_core_rolly_queue_pkg.sv
// Shared constants for the speculative ("rolly") FE->BE queue.
// The payload type stays with the fe/be interface, so this package holds only default sizing.
package bp_core_rolly_queue_pkg;

    localparam int unsigned rq_width_dflt_lp = 32'd64;
    localparam int unsigned rq_els_dflt_lp   = 32'd8;
    localparam int unsigned rq_rtv_dflt_lp   = 32'd1;

endpackage : bp_core_rolly_queue_pkg

// File: rtl/bp_core_rolly_queue_chk.sv
// Protocol checker for the rolly queue handshake and control inputs.
module bp_core_rolly_queue_chk #(
    parameter int unsigned ready_THEN_valid_p = 32'd1
) (
    input logic clk_i,
    input logic reset_i,
    input logic v_i,
    input logic ready_o,
    input logic v_o,
    input logic yumi_i,
    input logic deq_v_i,
    input logic roll_v_i,
    input logic clr_v_i
);

    logic [1:0] ctrl_cnt_s;
    assign ctrl_cnt_s = {1'b0, clr_v_i} + {1'b0, roll_v_i} + {1'b0, deq_v_i};

    // sample the interface once per cycle outside reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("rolly_queue: yumi_i with no unread entry");
            assert (!((ready_THEN_valid_p != 32'd0) && v_i && !ready_o))
                else $error("rolly_queue: v_i while ready_o low");
            if (ctrl_cnt_s > 2'd1) begin
                $warning("rolly_queue: multiple of clr/roll/deq asserted");
            end
        end
    end

endmodule : bp_core_rolly_queue_chk

// File: rtl/bp_core_rolly_queue_mem.sv
// Storage array for the rolly queue: one synchronous write port, one asynchronous read port.
module bp_core_rolly_queue_mem
    import bp_core_rolly_queue_pkg::*;
#(
    parameter int unsigned width_p = rq_width_dflt_lp,
    parameter int unsigned els_p   = rq_els_dflt_lp,
    localparam int unsigned lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [lg_els_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic [lg_els_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // write port; storage needs no reset since pointers gate every read
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule : bp_core_rolly_queue_mem

// File: rtl/bp_core_rolly_queue.sv
// Speculative FIFO: reads advance rptr, deq commits up to rptr, roll rewinds to cptr, clr drops all.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module bp_core_rolly_queue
    import bp_core_rolly_queue_pkg::*;
#(
    parameter int unsigned width_p            = rq_width_dflt_lp,
    parameter int unsigned els_p              = rq_els_dflt_lp,
    parameter int unsigned ready_THEN_valid_p = rq_rtv_dflt_lp,
    localparam int unsigned lg_els_lp = $clog2(els_p),
    localparam int unsigned ptr_w_lp  = lg_els_lp + 32'd1,
    localparam int unsigned cnt_w_lp  = $clog2(els_p + 32'd1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                v_i,
    output logic                ready_o,
    output logic [width_p-1:0]  data_o,
    output logic                v_o,
    input  logic                yumi_i,
    input  logic                deq_v_i,
    input  logic                roll_v_i,
    input  logic                clr_v_i,
    output logic [cnt_w_lp-1:0] count_o,
    output logic [cnt_w_lp-1:0] spec_count_o
);

    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1'b1);
    localparam logic [ptr_w_lp-1:0] ptr_full_lp = ptr_w_lp'(els_p);

    logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_w_lp-1:0] wptr_n_s, rptr_n_s, cptr_n_s;
    logic [ptr_w_lp-1:0] commit_occ_s, spec_occ_s;
    logic                enq_s;

    assign commit_occ_s = wptr_r - cptr_r;
    assign spec_occ_s   = wptr_r - rptr_r;

    // uncommitted reads still hold their slots, so fullness is measured from cptr
    assign ready_o      = (commit_occ_s != ptr_full_lp);
    assign v_o          = (rptr_r != wptr_r);
    assign count_o      = cnt_w_lp'(commit_occ_s);
    assign spec_count_o = cnt_w_lp'(spec_occ_s);
    assign enq_s        = v_i & ready_o;

    // next-pointer selection with clr > roll > deq priority; yumi rides along only with deq or alone
    always_comb begin
        wptr_n_s = wptr_r;
        rptr_n_s = rptr_r;
        cptr_n_s = cptr_r;
        if (enq_s) begin
            wptr_n_s = wptr_r + ptr_one_lp;
        end else begin
            wptr_n_s = wptr_r;
        end
        if (clr_v_i) begin
            rptr_n_s = wptr_r;
            cptr_n_s = wptr_r;
        end else if (roll_v_i) begin
            rptr_n_s = cptr_r;
            cptr_n_s = cptr_r;
        end else if (deq_v_i) begin
            cptr_n_s = rptr_r;
            rptr_n_s = yumi_i ? (rptr_r + ptr_one_lp) : rptr_r;
        end else begin
            cptr_n_s = cptr_r;
            rptr_n_s = yumi_i ? (rptr_r + ptr_one_lp) : rptr_r;
        end
    end

    // pointer registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n_s;
            rptr_r <= rptr_n_s;
            cptr_r <= cptr_n_s;
        end
    end

    bp_core_rolly_queue_mem #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (enq_s),
        .w_addr_i (wptr_r[lg_els_lp-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr_r[lg_els_lp-1:0]),
        .r_data_o (data_o)
    );

    bp_core_rolly_queue_chk #(
        .ready_THEN_valid_p (ready_THEN_valid_p)
    ) u_chk (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i),
        .deq_v_i  (deq_v_i),
        .roll_v_i (roll_v_i),
        .clr_v_i  (clr_v_i)
    );

endmodule : bp_core_rolly_queue
